// File: rtl/grid_state_monitor_pkg.sv
// Shared types and default thresholds for the grid state monitor.
// Default thresholds are provided so a top level can tie the threshold ports off.
package grid_state_monitor_pkg;

    typedef enum logic [1:0] {
        GRID_NORMAL   = 2'd0,
        GRID_UNSTABLE = 2'd1,
        GRID_CRITICAL = 2'd2
    } grid_state_t;

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_NORMAL   = 2'd1,
        S_UNSTABLE = 2'd2,
        S_CRITICAL = 2'd3
    } monitor_state_t;

    localparam logic [15:0] v_critico_low_adc  = 16'd1000;
    localparam logic [15:0] v_critico_high_adc = 16'd3000;
    localparam logic [15:0] v_instavel_min_adc = 16'd1800;
    localparam logic [15:0] v_instavel_max_adc = 16'd2200;
    localparam logic [15:0] i_max_adc          = 16'd4000;

    // While the window is still filling the grid is reported as unstable.
    function automatic grid_state_t to_grid(input monitor_state_t s);
        case (s)
            S_NORMAL:   return GRID_NORMAL;
            S_UNSTABLE: return GRID_UNSTABLE;
            S_CRITICAL: return GRID_CRITICAL;
            S_FILL:     return GRID_UNSTABLE;
            default:    return GRID_UNSTABLE;
        endcase
    endfunction

endpackage

// File: rtl/moving_avg_pow2.sv
// Moving average over a power-of-two window: circular history buffer, running sum
// and fill counter. avg_upd_o marks the cycle in which avg_o first includes a new sample.
module moving_avg_pow2 #(
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [DATA_W-1:0] avg_o,
    output logic              avg_valid_o,
    output logic              avg_upd_o
);

    localparam int D      = 1 << AVG_LOG2;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    logic [DATA_W-1:0]   hist_q [D];
    logic [AVG_LOG2-1:0] wr_ptr_q;
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic [FILL_W-1:0]   fill_q;
    logic                valid_q;
    logic                upd_q;

    // The sum always covers exactly the buffer contents, so it cannot underflow.
    assign sum_d = sum_q + SUM_W'(sample_i) - SUM_W'(hist_q[wr_ptr_q]);

    // History, running sum, fill tracking; the pointer wraps by its own width.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < D; k++) begin
                hist_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            sum_q    <= '0;
            fill_q   <= '0;
            valid_q  <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            upd_q <= sample_valid_i;
            if (sample_valid_i) begin
                hist_q[wr_ptr_q] <= sample_i;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
                sum_q            <= sum_d;
                if (fill_q != FILL_W'(D)) begin
                    fill_q <= fill_q + 1'b1;
                end
                valid_q <= (fill_q >= FILL_W'(D - 1));
            end
        end
    end

    assign avg_o       = sum_q[SUM_W-1:AVG_LOG2];
    assign avg_valid_o = valid_q;
    assign avg_upd_o   = upd_q;

endmodule

// File: rtl/grid_state_monitor.sv
// Grid state classifier: moving-average voltage, programmable windows, escalation
// on the next edge and debounced one-level-at-a-time de-escalation with hysteresis.
module grid_state_monitor
    import grid_state_monitor_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 2,
    parameter int DEBOUNCE = 8,
    parameter int HYST     = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] grid_voltage_adc,
    input  logic [DATA_W-1:0] grid_current_sensor,
    input  logic              ml_predict_instability,
    input  logic [DATA_W-1:0] thr_crit_low,
    input  logic [DATA_W-1:0] thr_crit_high,
    input  logic [DATA_W-1:0] thr_unst_min,
    input  logic [DATA_W-1:0] thr_unst_max,
    input  logic [DATA_W-1:0] thr_i_max,
    output logic [DATA_W-1:0] measured_voltage,
    output logic              avg_valid,
    output grid_state_t       grid_state,
    output logic              state_changed,
    output logic [CNT_W-1:0]  critical_event_count
);

    localparam int CMP_W = DATA_W + 1;
    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam logic [CMP_W-1:0] HYST_X   = CMP_W'(HYST);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

    logic [DATA_W-1:0] avg_s;
    logic              avg_valid_s;
    logic              avg_upd_s;
    logic [DATA_W-1:0] i_q;
    logic [CMP_W-1:0]  avg_x_s;
    logic              i_over_s;
    logic              raw_crit_s;
    logic              raw_unst_s;
    logic              qual_below_crit_s;
    logic              qual_norm_s;
    monitor_state_t    raw_state_s;

    monitor_state_t    state_q;
    monitor_state_t    state_d;
    logic [DEB_W-1:0]  deb_q;
    logic [DEB_W-1:0]  deb_d;
    grid_state_t       grid_q;
    grid_state_t       grid_d;
    logic              changed_q;
    logic [CNT_W-1:0]  cnt_q;

    function automatic logic [CMP_W-1:0] ext(input logic [DATA_W-1:0] v);
        return {1'b0, v};
    endfunction

    moving_avg_pow2 #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_valid_i (sample_valid),
        .sample_i       (grid_voltage_adc),
        .avg_o          (avg_s),
        .avg_valid_o    (avg_valid_s),
        .avg_upd_o      (avg_upd_s)
    );

    assign avg_x_s    = ext(avg_s);
    assign i_over_s   = (i_q > thr_i_max);
    assign raw_crit_s = (avg_s < thr_crit_low) || (avg_s > thr_crit_high) || i_over_s;
    assign raw_unst_s = (avg_s < thr_unst_min) || (avg_s > thr_unst_max) || ml_predict_instability;

    // Hysteresis bands are compared one bit wider and without subtraction so no bound wraps.
    assign qual_below_crit_s = (avg_x_s >= ext(thr_crit_low) + HYST_X)
                            && (avg_x_s + HYST_X <= ext(thr_crit_high))
                            && !i_over_s;
    assign qual_norm_s = qual_below_crit_s
                      && (avg_x_s >= ext(thr_unst_min) + HYST_X)
                      && (avg_x_s + HYST_X <= ext(thr_unst_max))
                      && !ml_predict_instability;

    // Unfiltered class of the current average.
    always_comb begin
        raw_state_s = S_NORMAL;
        if (raw_crit_s) begin
            raw_state_s = S_CRITICAL;
        end else if (raw_unst_s) begin
            raw_state_s = S_UNSTABLE;
        end else begin
            raw_state_s = S_NORMAL;
        end
    end

    // Next state: escalation is checked first so it always beats a debounce completion.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        case (state_q)
            S_FILL: begin
                deb_d = '0;
                if (avg_valid_s) begin
                    state_d = raw_state_s;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_NORMAL: begin
                deb_d = '0;
                if (raw_state_s != S_NORMAL) begin
                    state_d = raw_state_s;
                end else begin
                    state_d = S_NORMAL;
                end
            end
            S_UNSTABLE: begin
                if (raw_state_s == S_CRITICAL) begin
                    state_d = S_CRITICAL;
                    deb_d   = '0;
                end else if (!qual_norm_s) begin
                    deb_d = '0;
                end else if (avg_upd_s) begin
                    if (deb_q == DEB_LAST) begin
                        state_d = S_NORMAL;
                        deb_d   = '0;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d = deb_q;
                end
            end
            S_CRITICAL: begin
                if (!qual_below_crit_s) begin
                    deb_d = '0;
                end else if (avg_upd_s) begin
                    if (deb_q == DEB_LAST) begin
                        state_d = S_UNSTABLE;
                        deb_d   = '0;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d = deb_q;
                end
            end
            default: begin
                state_d = S_FILL;
                deb_d   = '0;
            end
        endcase
    end

    assign grid_d = to_grid(state_d);

    // State register with registered telemetry outputs and captured current sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_FILL;
            deb_q     <= '0;
            grid_q    <= GRID_UNSTABLE;
            changed_q <= 1'b0;
            cnt_q     <= '0;
            i_q       <= '0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            grid_q    <= grid_d;
            changed_q <= (grid_d != grid_q);
            if ((state_d == S_CRITICAL) && (state_q != S_CRITICAL) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (sample_valid) begin
                i_q <= grid_current_sensor;
            end
        end
    end

    assign measured_voltage     = avg_s;
    assign avg_valid            = avg_valid_s;
    assign grid_state           = grid_q;
    assign state_changed        = changed_q;
    assign critical_event_count = cnt_q;

endmodule

// File: tb/tb_grid_state_monitor.sv
// Directed and random stimulus for grid_state_monitor, checked against an
// integer-level reference model (window queue, numeric severity levels).
module tb_grid_state_monitor;
    import grid_state_monitor_pkg::*;

    localparam int D   = 4;
    localparam int DEB = 4;
    localparam int HY  = 16;
    localparam int CL  = int'(v_critico_low_adc);
    localparam int CH  = int'(v_critico_high_adc);
    localparam int UMN = int'(v_instavel_min_adc);
    localparam int UMX = int'(v_instavel_max_adc);
    localparam int IMX = int'(i_max_adc);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic        ml = 1'b0;
    logic [15:0] volt = 16'd0;
    logic [15:0] cur = 16'd0;

    logic [15:0] meas_a, meas_b;
    logic        aval_a, aval_b, chg_a, chg_b;
    grid_state_t grid_a, grid_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    grid_state_monitor #(.DATA_W(16), .AVG_LOG2(2), .DEBOUNCE(DEB), .HYST(HY), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .grid_voltage_adc(volt), .grid_current_sensor(cur), .ml_predict_instability(ml),
        .thr_crit_low(v_critico_low_adc), .thr_crit_high(v_critico_high_adc),
        .thr_unst_min(v_instavel_min_adc), .thr_unst_max(v_instavel_max_adc), .thr_i_max(i_max_adc),
        .measured_voltage(meas_a), .avg_valid(aval_a), .grid_state(grid_a),
        .state_changed(chg_a), .critical_event_count(cnt_a));

    grid_state_monitor #(.DATA_W(16), .AVG_LOG2(2), .DEBOUNCE(DEB), .HYST(HY), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .grid_voltage_adc(volt), .grid_current_sensor(cur), .ml_predict_instability(ml),
        .thr_crit_low(v_critico_low_adc), .thr_crit_high(v_critico_high_adc),
        .thr_unst_min(v_instavel_min_adc), .thr_unst_max(v_instavel_max_adc), .thr_i_max(i_max_adc),
        .measured_voltage(meas_b), .avg_valid(aval_b), .grid_state(grid_b),
        .state_changed(chg_b), .critical_event_count(cnt_b));

    int vectors = 0;
    int miscompares = 0;
    int n_checks = 0;

    // Applied stimulus as plain integers for the model.
    int in_rst, in_valid, in_volt, in_cur, in_ml;

    // Reference model: level -1 = filling, 0 = normal, 1 = unstable, 2 = critical.
    int hist[$];
    int m_filled, m_avg, m_iq, m_upd, m_valid, level, m_deb, m_grid, m_chg, m_cnt;

    function automatic int grid_code(input int g);
        case (g)
            0:       return int'(GRID_NORMAL);
            2:       return int'(GRID_CRITICAL);
            default: return int'(GRID_UNSTABLE);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int raw, old_level, new_grid, sum;
        bit qbc, qn, below;
        if (in_rst != 0) begin
            hist = '{0, 0, 0, 0};
            m_filled = 0; m_avg = 0; m_iq = 0; m_upd = 0; m_valid = 0;
            level = -1; m_deb = 0; m_grid = 1; m_chg = 0; m_cnt = 0;
        end else begin
            if (m_avg < CL || m_avg > CH || m_iq > IMX) raw = 2;
            else if (m_avg < UMN || m_avg > UMX || in_ml != 0) raw = 1;
            else raw = 0;
            qbc = (m_avg >= CL + HY) && (m_avg + HY <= CH) && (m_iq <= IMX);
            qn  = qbc && (m_avg >= UMN + HY) && (m_avg + HY <= UMX) && (in_ml == 0);
            old_level = level;
            below = (level == 2) ? qbc : ((level == 1) ? qn : 1'b0);
            if (level < 0) begin
                if (m_valid != 0) level = raw;
            end else if (raw > level) begin
                level = raw; m_deb = 0;
            end else if (!below) begin
                m_deb = 0;
            end else if (m_upd != 0) begin
                m_deb++;
                if (m_deb == DEB) begin level--; m_deb = 0; end
            end
            new_grid = (level < 0) ? 1 : level;
            m_chg = (new_grid != m_grid) ? 1 : 0;
            m_grid = new_grid;
            if (level == 2 && old_level != 2) m_cnt++;
            if (in_valid != 0) begin
                hist.push_back(in_volt);
                void'(hist.pop_front());
                if (m_filled < D) m_filled++;
                m_iq = in_cur;
            end
            sum = 0;
            foreach (hist[k]) sum += hist[k];
            m_avg = sum / D;
            m_upd = in_valid;
            m_valid = (m_filled == D) ? 1 : 0;
        end
    endtask

    task automatic step(input int v, input int vv, input int cc, input int mm, input int rr);
        in_valid = v; in_volt = vv; in_cur = cc; in_ml = mm; in_rst = rr;
        reset_n = (rr == 0); sample_valid = (v != 0); volt = 16'(vv); cur = 16'(cc); ml = (mm != 0);
        @(posedge clk);
        model_edge();
        #1;
        vectors++;
        chk("measured", 32'(meas_a), m_avg);
        chk("avg_valid", 32'(aval_a), m_valid);
        chk("grid_state", 32'(grid_a), grid_code(m_grid));
        chk("state_changed", 32'(chg_a), m_chg);
        chk("crit_count", 32'(cnt_a), (m_cnt > 65535) ? 65535 : m_cnt);
        chk("crit_count_w2", 32'(cnt_b), (m_cnt > 3) ? 3 : m_cnt);
        chk("grid_state_w2", 32'(grid_b), grid_code(m_grid));
    endtask

    task automatic samples(input int n, input int vv, input int cc);
        for (int k = 0; k < n; k++) step(1, vv, cc, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, in_volt, in_cur, 0, 0);
    endtask

    initial begin
        // Reset state.
        step(0, 0, 100, 0, 1);
        step(0, 0, 100, 0, 1);
        chk("reset_grid", 32'(grid_a), 32'(GRID_UNSTABLE));
        chk("reset_valid", 32'(aval_a), 32'd0);

        // Fill with 2000: valid on 4th sample, NORMAL one cycle later with a single pulse.
        samples(3, 2000, 100);
        chk("fill_grid", 32'(grid_a), 32'(GRID_UNSTABLE));
        samples(1, 2000, 100);
        chk("fill_meas", 32'(meas_a), 32'd2000);
        chk("fill_valid", 32'(aval_a), 32'd1);
        idle(1);
        chk("fill_normal", 32'(grid_a), 32'(GRID_NORMAL));
        chk("fill_pulse", 32'(chg_a), 32'd1);
        idle(1);
        chk("fill_pulse_end", 32'(chg_a), 32'd0);

        // Drop to 900: 1725, 1450, 1175, 900 -> CRITICAL.
        samples(1, 900, 100);
        chk("drop_avg1", 32'(meas_a), 32'd1725);
        samples(3, 900, 100);
        idle(1);
        chk("drop_crit", 32'(grid_a), 32'(GRID_CRITICAL));
        chk("drop_count", 32'(cnt_a), 32'd1);

        // Inside the hysteresis band stays CRITICAL; dips restart the debounce.
        samples(4, 1010, 100);
        idle(2);
        chk("band_hold", 32'(grid_a), 32'(GRID_CRITICAL));
        samples(2, 1100, 100);
        samples(1, 990, 100);
        samples(1, 700, 100);
        samples(2, 1100, 100);
        chk("dip_restart", 32'(grid_a), 32'(GRID_CRITICAL));
        samples(6, 1100, 100);
        idle(1);
        chk("crit_to_unst", 32'(grid_a), 32'(GRID_UNSTABLE));

        // Back to NORMAL, then a one-cycle ML prediction.
        samples(8, 2000, 100);
        idle(1);
        chk("recover_normal", 32'(grid_a), 32'(GRID_NORMAL));
        step(0, 2000, 100, 1, 0);
        chk("ml_unst", 32'(grid_a), 32'(GRID_UNSTABLE));
        samples(4, 2000, 100);
        chk("ml_not_before", 32'(grid_a), 32'(GRID_UNSTABLE));
        idle(1);
        chk("ml_normal", 32'(grid_a), 32'(GRID_NORMAL));

        // Overcurrent entries, repeated to saturate the narrow counter.
        for (int r = 0; r < 4; r++) begin
            samples(1, 2000, 4001);
            chk("oc_latency", 32'(grid_a), 32'(GRID_NORMAL));
            idle(1);
            chk("oc_crit", 32'(grid_a), 32'(GRID_CRITICAL));
            samples(10, 2000, 100);
            idle(1);
        end
        chk("oc_count", 32'(cnt_a), 32'd5);
        chk("oc_sat", 32'(cnt_b), 32'd3);

        // Reset while CRITICAL with the debounce mid-count.
        samples(1, 2000, 4001);
        idle(1);
        samples(3, 2000, 100);
        step(0, 2000, 100, 0, 1);
        chk("mid_rst_meas", 32'(meas_a), 32'd0);
        chk("mid_rst_grid", 32'(grid_a), 32'(GRID_UNSTABLE));
        chk("mid_rst_count", 32'(cnt_a), 32'd0);
        samples(4, 2000, 100);
        chk("refill_valid", 32'(aval_a), 32'd1);
        idle(1);
        chk("refill_normal", 32'(grid_a), 32'(GRID_NORMAL));

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            int v, vv, cc, mm, rr;
            rr = ($urandom_range(0, 299) == 0) ? 1 : 0;
            v  = ($urandom_range(0, 9) < 7) ? 1 : 0;
            vv = int'($urandom_range(700, 2400));
            cc = ($urandom_range(0, 39) == 0) ? int'($urandom_range(3990, 5000)) : 100;
            mm = ($urandom_range(0, 29) == 0) ? 1 : 0;
            step(v, vv, cc, mm, rr);
        end

        $display("checks performed: %0d", n_checks);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
